// File: rtl/usb_bridge_fifo_lvl.sv
// Parametrised first-word-fall-through FIFO for the USB bridge RX/TX paths.
// Any depth, occupancy level, almost-full/empty thresholds, flush, sticky errors, high-water mark.
module usb_bridge_fifo_lvl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter int AFULL_LVL  = 3,
    parameter int AEMPTY_LVL = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [WIDTH-1:0]  data_in_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [WIDTH-1:0]  data_out_o,
    output logic              accept_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   level_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic [ADDR_W:0]   hwm_o
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_L  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   AEMPTY_L = (ADDR_W+1)'(AEMPTY_LVL);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [ADDR_W:0]   hwm_q, hwm_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              push_ok, pop_ok;

    // Handshakes decode from registered level only, so no push/pop -> accept/valid path.
    assign accept_o       = (level_q != DEPTH_L);
    assign valid_o        = (level_q != '0);
    assign level_o        = level_q;
    assign hwm_o          = hwm_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign almost_full_o  = (level_q >= AFULL_L);
    assign almost_empty_o = (level_q <= AEMPTY_L);
    assign data_out_o     = mem_q[rd_ptr_q];

    assign push_ok = push_i & accept_o & ~flush_i;
    assign pop_ok  = pop_i & valid_o & ~flush_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hwm_d    = hwm_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            hwm_d    = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            // Explicit wrap so non-power-of-2 depths work.
            if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (level_d > hwm_q) hwm_d = level_d;
            if (push_i && !accept_o) ovf_d = 1'b1;
            if (pop_i && !valid_o)   udf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hwm_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hwm_q    <= hwm_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // NOTE: storage is deliberately not reset; valid_o gates every read, and a reset-free array maps to RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_in_i;
    end

endmodule
